// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX/MEM pipeline register with a valid/ready handshake on both
// sides, bubble-gated memory/writeback controls and an EX-stage forwarding tap.
//
// Build option:
//   EX_MEM_SKID_EN  defined   -> one-entry skid buffer; in_ready is a register
//                                equal to !skid_valid, so out_ready never
//                                reaches in_ready combinationally.
//                   undefined -> single output register; in_ready is
//                                out_ready || !out_valid (capacity 1 entry).
module ex_mem_stage #(
  parameter int DATA_W = 32,
  parameter int RD_W   = 5
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        MEM_Signal,
  input  logic [1:0]        MEM_WB_Signal,
  input  logic [DATA_W-1:0] ALUOut,
  input  logic [DATA_W-1:0] DataBusB,
  input  logic [RD_W-1:0]   EX_Reg_RD,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              EX_MEM_Read_Con,
  output logic              EX_MEM_Write_Con,
  output logic              EX_MEM_MEMtoReg,
  output logic              EX_MEM_RegWre,
  output logic [DATA_W-1:0] EX_MEM_ALUOut,
  output logic [DATA_W-1:0] EX_MEM_DataBusB,
  output logic [RD_W-1:0]   EX_MEM_Reg_RD,
  output logic              fwd_en,
  output logic [RD_W-1:0]   fwd_rd,
  output logic [DATA_W-1:0] fwd_data
);

  // One pipeline entry: memory/writeback controls plus its data.
  typedef struct packed {
    logic              rd_en;
    logic              wr_en;
    logic              mem_to_reg;
    logic              reg_wre;
    logic [DATA_W-1:0] alu_out;
    logic [DATA_W-1:0] bus_b;
    logic [RD_W-1:0]   rd;
  } entry_t;

  entry_t in_entry;
  entry_t out_q;
  logic   out_valid_q;
  logic   accept;
  logic   out_load;

  assign in_entry = '{
    rd_en:      MEM_Signal[1],
    wr_en:      MEM_Signal[0],
    mem_to_reg: MEM_WB_Signal[1],
    reg_wre:    MEM_WB_Signal[0],
    alu_out:    ALUOut,
    bus_b:      DataBusB,
    rd:         EX_Reg_RD
  };

  // The output register may take a new entry when empty or emptying this cycle.
  assign out_load = !out_valid_q || out_ready;

`ifdef EX_MEM_SKID_EN
  entry_t skid_q;
  logic   skid_valid_q;
  logic   in_ready_q;

  // in_ready comes straight from a flop that tracks !skid_valid.
  assign in_ready = in_ready_q;
  assign accept   = in_valid && in_ready_q;

  // Output register plus skid entry; the skid entry always drains first.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      // NOTE: the data fields are reset too, because reset must leave every
      // EX_MEM_* output at 0, not just the valid flags.
      out_valid_q  <= 1'b0;
      out_q        <= '0;
      skid_valid_q <= 1'b0;
      skid_q       <= '0;
      in_ready_q   <= 1'b1;
    end else if (flush) begin
      // Flush wins over accept and transfer-out; held data is left as is.
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else if (out_load) begin
      if (skid_valid_q) begin
        // in_ready is low while the skid is full, so no accept can collide.
        out_q        <= skid_q;
        out_valid_q  <= 1'b1;
        skid_valid_q <= 1'b0;
        in_ready_q   <= 1'b1;
      end else begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        out_valid_q <= accept;
        if (accept) out_q <= in_entry;
      end
    end else if (accept) begin
      // Output is stalled: park the new entry in the skid buffer.
      skid_q       <= in_entry;
      skid_valid_q <= 1'b1;
      in_ready_q   <= 1'b0;
    end
  end
`else
  // Without a skid buffer the stage can accept only when the output frees up.
  assign in_ready = out_ready || !out_valid_q;
  assign accept   = in_valid && in_ready;

  // Single output register; flush wins over accept and transfer-out.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
    end else if (out_load) begin
      out_valid_q <= accept;
      if (accept) out_q <= in_entry;
    end
  end
`endif

  // Side-effecting controls are gated to 0 while no entry is held (bubble);
  // MEMtoReg and the data fields simply keep their last value.
  assign out_valid        = out_valid_q;
  assign EX_MEM_Read_Con  = out_valid_q & out_q.rd_en;
  assign EX_MEM_Write_Con = out_valid_q & out_q.wr_en;
  assign EX_MEM_RegWre    = out_valid_q & out_q.reg_wre;
  assign EX_MEM_MEMtoReg  = out_q.mem_to_reg;
  assign EX_MEM_ALUOut    = out_q.alu_out;
  assign EX_MEM_DataBusB  = out_q.bus_b;
  assign EX_MEM_Reg_RD    = out_q.rd;

  // A load's result is not available in EX/MEM, and r0 is never forwarded.
  assign fwd_en   = out_valid_q & out_q.reg_wre & ~out_q.rd_en & (|out_q.rd);
  assign fwd_rd   = out_q.rd;
  assign fwd_data = out_q.alu_out;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage; expectations follow EX_MEM_SKID_EN when set.
module tb_ex_mem_stage;

  localparam int DATA_W = 32;
  localparam int RD_W   = 5;

  logic              CLK = 1'b0;
  logic              RST;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        MEM_Signal;
  logic [1:0]        MEM_WB_Signal;
  logic [DATA_W-1:0] ALUOut;
  logic [DATA_W-1:0] DataBusB;
  logic [RD_W-1:0]   EX_Reg_RD;
  logic              out_valid;
  logic              out_ready;
  logic              EX_MEM_Read_Con;
  logic              EX_MEM_Write_Con;
  logic              EX_MEM_MEMtoReg;
  logic              EX_MEM_RegWre;
  logic [DATA_W-1:0] EX_MEM_ALUOut;
  logic [DATA_W-1:0] EX_MEM_DataBusB;
  logic [RD_W-1:0]   EX_MEM_Reg_RD;
  logic              fwd_en;
  logic [RD_W-1:0]   fwd_rd;
  logic [DATA_W-1:0] fwd_data;

  int passed = 0;
  int total  = 0;

  ex_mem_stage #(.DATA_W(DATA_W), .RD_W(RD_W)) dut (
    .CLK              (CLK),
    .RST              (RST),
    .flush            (flush),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .MEM_Signal       (MEM_Signal),
    .MEM_WB_Signal    (MEM_WB_Signal),
    .ALUOut           (ALUOut),
    .DataBusB         (DataBusB),
    .EX_Reg_RD        (EX_Reg_RD),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .EX_MEM_Read_Con  (EX_MEM_Read_Con),
    .EX_MEM_Write_Con (EX_MEM_Write_Con),
    .EX_MEM_MEMtoReg  (EX_MEM_MEMtoReg),
    .EX_MEM_RegWre    (EX_MEM_RegWre),
    .EX_MEM_ALUOut    (EX_MEM_ALUOut),
    .EX_MEM_DataBusB  (EX_MEM_DataBusB),
    .EX_MEM_Reg_RD    (EX_MEM_Reg_RD),
    .fwd_en           (fwd_en),
    .fwd_rd           (fwd_rd),
    .fwd_data         (fwd_data)
  );

  always #5 CLK = ~CLK;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Present one EX entry (stimulus only).
  task automatic drive(input logic v, input logic [1:0] mem, input logic [1:0] wb,
                       input logic [DATA_W-1:0] alu, input logic [RD_W-1:0] rd);
    in_valid      = v;
    MEM_Signal    = mem;
    MEM_WB_Signal = wb;
    ALUOut        = alu;
    DataBusB      = alu ^ 32'hFFFF_0000;
    EX_Reg_RD     = rd;
  endtask

  task automatic test_reset();
    RST = 1'b0; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 2'b00, 2'b00, '0, '0);
    #12;
    total++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid);
    else passed++;
    total++;
    if (EX_MEM_ALUOut !== '0 || EX_MEM_Reg_RD !== '0 || fwd_en !== 1'b0)
      $display("FAIL reset_data: alu=%h rd=%0d fwd_en=%b want 0/0/0", EX_MEM_ALUOut, EX_MEM_Reg_RD, fwd_en);
    else passed++;
    RST = 1'b1;
    tick();
    total++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready);
    else passed++;
  endtask

  task automatic test_stream();
    logic [DATA_W-1:0] vals [3];
    vals[0] = 32'h10; vals[1] = 32'h20; vals[2] = 32'h30;
    out_ready = 1'b1;
    drive(1'b1, 2'b00, 2'b11, vals[0], 5'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (out_valid !== 1'b1 || EX_MEM_ALUOut !== vals[i])
        $display("FAIL stream_%0d: valid=%b alu=%h want 1/%h", i, out_valid, EX_MEM_ALUOut, vals[i]);
      else passed++;
      if (i < 2) drive(1'b1, 2'b00, 2'b11, vals[i+1], 5'd1);
      else drive(1'b0, 2'b00, 2'b00, '0, '0);
    end
    tick();
    total++;
    if (out_valid !== 1'b0) $display("FAIL stream_drain: got %b want 0", out_valid);
    else passed++;
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive(1'b1, 2'b01, 2'b00, 32'hA1, 5'd4);
    tick();
    total++;
    if (out_valid !== 1'b1 || EX_MEM_ALUOut !== 32'hA1)
      $display("FAIL bp_first: valid=%b alu=%h want 1/a1", out_valid, EX_MEM_ALUOut);
    else passed++;
    drive(1'b1, 2'b01, 2'b00, 32'hA2, 5'd5);
    tick();
    total++;
    if (EX_MEM_ALUOut !== 32'hA1 || EX_MEM_Reg_RD !== 5'd4 || EX_MEM_Write_Con !== 1'b1)
      $display("FAIL bp_hold: alu=%h rd=%0d wr=%b want a1/4/1", EX_MEM_ALUOut, EX_MEM_Reg_RD, EX_MEM_Write_Con);
    else passed++;
    total++;
    if (in_ready !== 1'b0) $display("FAIL bp_in_ready: got %b want 0", in_ready);
    else passed++;
    drive(1'b0, 2'b00, 2'b00, '0, '0);
    out_ready = 1'b1;
    tick();
`ifdef EX_MEM_SKID_EN
    total++;
    if (out_valid !== 1'b1 || EX_MEM_ALUOut !== 32'hA2)
      $display("FAIL bp_drain_second: valid=%b alu=%h want 1/a2", out_valid, EX_MEM_ALUOut);
    else passed++;
    tick();
`endif
    total++;
    if (out_valid !== 1'b0) $display("FAIL bp_empty: got %b want 0", out_valid);
    else passed++;
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive(1'b1, 2'b01, 2'b00, 32'hB1, 5'd6);
    tick();
    total++;
    if (out_valid !== 1'b1 || EX_MEM_Write_Con !== 1'b1)
      $display("FAIL flush_pre: valid=%b wr=%b want 1/1", out_valid, EX_MEM_Write_Con);
    else passed++;
    flush = 1'b1;
    drive(1'b1, 2'b01, 2'b00, 32'hB2, 5'd7);
    tick();
    flush = 1'b0;
    drive(1'b0, 2'b00, 2'b00, '0, '0);
    total++;
    if (out_valid !== 1'b0 || EX_MEM_Write_Con !== 1'b0)
      $display("FAIL flush_kill: valid=%b wr=%b want 0/0", out_valid, EX_MEM_Write_Con);
    else passed++;
    total++;
    if (in_ready !== 1'b1) $display("FAIL flush_in_ready: got %b want 1", in_ready);
    else passed++;
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++;
      if (out_valid !== 1'b0) $display("FAIL flush_ghost_%0d: valid=%b alu=%h want 0", i, out_valid, EX_MEM_ALUOut);
      else passed++;
    end
  endtask

  task automatic test_forward();
    out_ready = 1'b1;
    drive(1'b1, 2'b00, 2'b01, 32'h55, 5'd3);
    tick();
    total++;
    if (fwd_en !== 1'b1 || fwd_rd !== 5'd3 || fwd_data !== 32'h55)
      $display("FAIL fwd_alu: en=%b rd=%0d data=%h want 1/3/55", fwd_en, fwd_rd, fwd_data);
    else passed++;
    drive(1'b1, 2'b00, 2'b01, 32'h55, 5'd0);
    tick();
    total++;
    if (fwd_en !== 1'b0 || EX_MEM_RegWre !== 1'b1)
      $display("FAIL fwd_r0: en=%b regwre=%b want 0/1", fwd_en, EX_MEM_RegWre);
    else passed++;
    drive(1'b1, 2'b10, 2'b01, 32'h55, 5'd3);
    tick();
    total++;
    if (fwd_en !== 1'b0 || EX_MEM_Read_Con !== 1'b1)
      $display("FAIL fwd_load: en=%b rd_con=%b want 0/1", fwd_en, EX_MEM_Read_Con);
    else passed++;
    drive(1'b0, 2'b00, 2'b00, '0, '0);
    tick();
    total++;
    if (fwd_en !== 1'b0 || EX_MEM_RegWre !== 1'b0 || EX_MEM_Read_Con !== 1'b0 || EX_MEM_ALUOut !== 32'h55)
      $display("FAIL fwd_bubble: en=%b regwre=%b rd_con=%b alu=%h want 0/0/0/55",
               fwd_en, EX_MEM_RegWre, EX_MEM_Read_Con, EX_MEM_ALUOut);
    else passed++;
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b0;
    drive(1'b1, 2'b01, 2'b01, 32'hC1, 5'd9);
    tick();
    drive(1'b1, 2'b01, 2'b01, 32'hC2, 5'd10);
    #2;
    RST = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || EX_MEM_Write_Con !== 1'b0 || EX_MEM_RegWre !== 1'b0 ||
        EX_MEM_Read_Con !== 1'b0 || EX_MEM_MEMtoReg !== 1'b0 || fwd_en !== 1'b0)
      $display("FAIL rst_mid_ctrl: valid=%b wr=%b regwre=%b rd=%b m2r=%b fwd=%b want all 0",
               out_valid, EX_MEM_Write_Con, EX_MEM_RegWre, EX_MEM_Read_Con, EX_MEM_MEMtoReg, fwd_en);
    else passed++;
    total++;
    if (EX_MEM_ALUOut !== '0) $display("FAIL rst_mid_alu: got %h want 0", EX_MEM_ALUOut);
    else passed++;
    drive(1'b0, 2'b00, 2'b00, '0, '0);
    tick();
    RST = 1'b1;
    out_ready = 1'b1;
    tick();
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL rst_mid_release: in_ready=%b valid=%b want 1/0", in_ready, out_valid);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_forward();
    test_reset_midstream();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
